// File: rtl/config_pkg.sv
`default_nettype none
// ============================================================================
// config_pkg -- core-wide configuration shared by trace/debug blocks.
// Revision: 1.0
// ============================================================================
package config_pkg;
  localparam int XLEN = 64;
endpackage
`default_nettype wire

// File: rtl/rvvi_pkg.sv
`default_nettype none
// ============================================================================
// rvvi_pkg -- compressed RVVI record layout, frame section sizes, FSM states.
// Revision: 1.0
// ============================================================================
package rvvi_pkg;
  localparam int PC_LSB        = 0;
  localparam int INSTR_LSB     = 64;
  localparam int MCYCLE_LSB    = 96;
  localparam int MINSTRET_LSB  = 160;
  localparam int TRAP_BIT      = 224;
  localparam int PRIV_LSB      = 225;
  localparam int GPRWEN_BIT    = 227;
  localparam int FPRWEN_BIT    = 228;
  localparam int CSRCNT_LSB    = 232;
  localparam int CSRCNT_W      = 12;
  localparam int GPR_LSB       = 248;
  localparam int FPR_LSB       = 320;
  localparam int CSR_LSB       = 392;
  localparam int CSR_SLOT_BITS = 80;

  localparam int BASE_BYTES = 31;
  localparam int REG_BYTES  = 9;
  localparam int CSR_BYTES  = 10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN0 = 3'd1,
    LEN1 = 3'd2,
    REQ  = 3'd3,
    GPR  = 3'd4,
    FPR  = 3'd5,
    CSR  = 3'd6
  } state_e;

  function automatic int rec_width(input int max_csrs);
    return CSR_LSB + max_csrs * CSR_SLOT_BITS;
  endfunction
endpackage
`default_nettype wire

// File: rtl/rvvififo.sv
`default_nettype none
// ============================================================================
// rvvififo -- whole-record FIFO; head record is visible combinationally.
// Revision: 1.0
// ============================================================================
module rvvififo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en, rd_en;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A push into a full FIFO is dropped even when a pop lands on the same edge.
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (rd_en) rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end
endmodule
`default_nettype wire

// File: rtl/rvvi_streamer.sv
`default_nettype none
// ============================================================================
// rvvi_streamer -- buffers retired-instruction records, serialises each one
// as a length-prefixed byte frame on a valid/ready stream. Revision: 1.0
// ============================================================================
module rvvi_streamer
  import rvvi_pkg::*;
#(
  parameter int MAX_CSRS = 5,
  parameter int DEPTH    = 4
) (
  input  logic                                     clk,
  input  logic                                     resetn,
  input  logic                                     valid,
  input  logic [CSR_LSB+MAX_CSRS*CSR_SLOT_BITS-1:0] rvvi,
  output logic                                     RvviStall,
  output logic [7:0]                               TxData,
  output logic                                     TxValid,
  output logic                                     TxLast,
  input  logic                                     TxReady,
  output logic                                     Overflow
);
  import config_pkg::*;

  localparam int W      = rec_width(MAX_CSRS);
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int SLOT_W = $clog2(MAX_CSRS+1);
  localparam int IDX_W  = $clog2(W);

  if (XLEN != 64) begin : g_xlen_check
    $error("rvvi_streamer supports XLEN=64 only");
  end
  if (DEPTH < 2 || DEPTH > 16) begin : g_depth_check
    $error("rvvi_streamer DEPTH must be in 2..16");
  end
  if (MAX_CSRS < 1) begin : g_csr_check
    $error("rvvi_streamer MAX_CSRS must be at least 1");
  end

  logic [W-1:0]      head;
  logic              full, empty, push, pop;
  logic [CNT_W-1:0]  count;

  state_e            state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              overflow_q, overflow_d;

  logic              gpr_en, fpr_en, fire, last, done;
  logic [CSRCNT_W-1:0] csr_raw;
  logic [SLOT_W-1:0] n_csr;
  logic [15:0]       len;
  logic [IDX_W-1:0]  bit_base;
  logic [7:0]        tx_data;

  assign push = valid & ~full;

  rvvififo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .wdata  (rvvi),
    .rdata  (head),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  assign gpr_en  = head[GPRWEN_BIT];
  assign fpr_en  = head[FPRWEN_BIT];
  assign csr_raw = head[CSRCNT_LSB +: CSRCNT_W];
  assign n_csr   = (csr_raw > CSRCNT_W'(MAX_CSRS)) ? SLOT_W'(MAX_CSRS) : SLOT_W'(csr_raw);
  assign len     = 16'(BASE_BYTES)
                 + (gpr_en ? 16'(REG_BYTES) : 16'd0)
                 + (fpr_en ? 16'(REG_BYTES) : 16'd0)
                 + 16'(CSR_BYTES) * 16'(n_csr);

  assign TxValid   = (state_q != IDLE);
  assign fire      = TxValid & TxReady;
  assign RvviStall = (count >= CNT_W'(DEPTH-1));
  assign overflow_d = overflow_q | (valid & full);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    slot_d   = slot_q;
    pop      = 1'b0;
    last     = 1'b0;
    done     = 1'b0;
    bit_base = '0;
    tx_data  = 8'h00;
    unique case (state_q)
      IDLE: begin
        idx_d  = '0;
        slot_d = '0;
        if (!empty) state_d = LEN0;
      end
      LEN0: begin
        tx_data = len[7:0];
        if (fire) state_d = LEN1;
      end
      LEN1: begin
        tx_data = len[15:8];
        if (fire) begin
          state_d = REQ;
          idx_d   = '0;
        end
      end
      REQ: begin
        bit_base = IDX_W'(8 * int'(idx_q));
        tx_data  = head[bit_base +: 8];
        if (idx_q == 5'(BASE_BYTES-1)) begin
          last = !gpr_en && !fpr_en && (n_csr == '0);
          if (fire) begin
            idx_d  = '0;
            slot_d = '0;
            if (gpr_en)              state_d = GPR;
            else if (fpr_en)         state_d = FPR;
            else if (n_csr != '0)    state_d = CSR;
            else                     done    = 1'b1;
          end
        end else if (fire) begin
          idx_d = idx_q + 5'd1;
        end
      end
      GPR: begin
        bit_base = IDX_W'(GPR_LSB + 8 * int'(idx_q));
        tx_data  = head[bit_base +: 8];
        if (idx_q == 5'(REG_BYTES-1)) begin
          last = !fpr_en && (n_csr == '0);
          if (fire) begin
            idx_d  = '0;
            slot_d = '0;
            if (fpr_en)              state_d = FPR;
            else if (n_csr != '0)    state_d = CSR;
            else                     done    = 1'b1;
          end
        end else if (fire) begin
          idx_d = idx_q + 5'd1;
        end
      end
      FPR: begin
        bit_base = IDX_W'(FPR_LSB + 8 * int'(idx_q));
        tx_data  = head[bit_base +: 8];
        if (idx_q == 5'(REG_BYTES-1)) begin
          last = (n_csr == '0);
          if (fire) begin
            idx_d  = '0;
            slot_d = '0;
            if (n_csr != '0) state_d = CSR;
            else             done    = 1'b1;
          end
        end else if (fire) begin
          idx_d = idx_q + 5'd1;
        end
      end
      CSR: begin
        bit_base = IDX_W'(CSR_LSB + CSR_SLOT_BITS * int'(slot_q) + 8 * int'(idx_q));
        tx_data  = head[bit_base +: 8];
        if (idx_q == 5'(CSR_BYTES-1)) begin
          last = (slot_q == n_csr - SLOT_W'(1));
          if (fire) begin
            idx_d = '0;
            if (last) done = 1'b1;
            else      slot_d = slot_q + SLOT_W'(1);
          end
        end else if (fire) begin
          idx_d = idx_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // The frame's final byte retires the head record; chain straight into the next one.
    if (done) begin
      pop     = 1'b1;
      idx_d   = '0;
      slot_d  = '0;
      state_d = (count > CNT_W'(1)) ? LEN0 : IDLE;
    end
  end

  assign TxData   = tx_data;
  assign TxLast   = last;
  assign Overflow = overflow_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      slot_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      slot_q     <= slot_d;
      overflow_q <= overflow_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_rvvi_streamer.sv
`default_nettype none
// ============================================================================
// tb_rvvi_streamer -- randomized record traffic against a byte-queue model.
// Revision: 1.0
// ============================================================================
module tb_rvvi_streamer;
  localparam int MAX_CSRS = 5;
  localparam int DEPTH    = 4;
  localparam int W        = 392 + MAX_CSRS * 80;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         valid = 1'b0;
  logic [W-1:0] rvvi = '0;
  logic         TxReady = 1'b0;
  logic         RvviStall, TxValid, TxLast, Overflow;
  logic [7:0]   TxData;

  always #5 clk = ~clk;

  rvvi_streamer #(
    .MAX_CSRS (MAX_CSRS),
    .DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .valid     (valid),
    .rvvi      (rvvi),
    .RvviStall (RvviStall),
    .TxData    (TxData),
    .TxValid   (TxValid),
    .TxLast    (TxLast),
    .TxReady   (TxReady),
    .Overflow  (Overflow)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  bit         exp_last_q[$];
  logic [7:0] obs_frame[$];
  logic [7:0] last_frame[$];
  int         inflight = 0;
  bit         ovf_m = 1'b0;
  bit         just_filled = 1'b0;
  int         frames_done = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Frame as a list of bytes, built straight from the record field rules.
  task automatic add_frame(input logic [W-1:0] r);
    logic [7:0] b[$];
    int g, f, n, len;
    g = int'(r[227]);
    f = int'(r[228]);
    n = int'(r[243:232]);
    if (n > MAX_CSRS) n = MAX_CSRS;
    len = 31 + 9 * g + 9 * f + 10 * n;
    b.push_back(len[7:0]);
    b.push_back(len[15:8]);
    for (int i = 0; i < 31; i++) b.push_back(r[8*i +: 8]);
    if (g != 0) for (int i = 0; i < 9; i++) b.push_back(r[248 + 8*i +: 8]);
    if (f != 0) for (int i = 0; i < 9; i++) b.push_back(r[320 + 8*i +: 8]);
    for (int s = 0; s < n; s++)
      for (int i = 0; i < 10; i++) b.push_back(r[392 + 80*s + 8*i +: 8]);
    for (int k = 0; k < b.size(); k++) begin
      exp_q.push_back(b[k]);
      exp_last_q.push_back(k == b.size() - 1);
    end
  endtask

  function automatic logic [W-1:0] rand_rec(input bit g, input bit f, input int n);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = 1'($urandom);
    r[227]     = g;
    r[228]     = f;
    r[243:232] = 12'(n);
    return r;
  endfunction

  // One clock: check outputs at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    bit         acc, lst, pushed;
    int         pre, mid;
    logic [7:0] dummy;
    @(negedge clk);
    chk("txvalid", TxValid, (inflight > 0) && !just_filled);
    chk("stall", RvviStall, inflight >= DEPTH - 1);
    chk("overflow", Overflow, ovf_m);
    acc = 1'b0;
    if (TxValid) begin
      if (exp_q.size() == 0) chk("tx_unexpected", TxValid, 0);
      else begin
        chk("txdata", TxData, exp_q[0]);
        chk("txlast", TxLast, exp_last_q[0]);
        acc = TxReady;
      end
    end
    if (acc) begin
      obs_frame.push_back(TxData);
      if (TxLast) begin
        last_frame = obs_frame;
        obs_frame.delete();
        frames_done++;
      end
    end
    @(posedge clk);
    pre = inflight;
    mid = inflight;
    if (acc) begin
      lst   = exp_last_q.pop_front();
      dummy = exp_q.pop_front();
      if (lst) mid--;
    end
    pushed = valid && (pre < DEPTH);
    if (valid && !pushed) ovf_m = 1'b1;
    just_filled = pushed && (mid == 0);
    inflight = mid + (pushed ? 1 : 0);
    if (pushed) add_frame(rvvi);
    #1;
  endtask

  task automatic do_reset();
    resetn  = 1'b0;
    valid   = 1'b0;
    TxReady = 1'b0;
    @(negedge clk);
    chk("rst_txvalid", TxValid, 0);
    chk("rst_txlast", TxLast, 0);
    chk("rst_txdata", TxData, 0);
    chk("rst_stall", RvviStall, 0);
    chk("rst_overflow", Overflow, 0);
    exp_q.delete();
    exp_last_q.delete();
    obs_frame.delete();
    inflight    = 0;
    ovf_m       = 1'b0;
    just_filled = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int ready_pct);
    int n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      TxReady = ($urandom_range(99) < ready_pct);
      cycle();
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] pc_bytes [8];
    pc_bytes = '{8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};

    do_reset();

    // GPR + 2 CSRs: 62-byte frame
    rvvi = rand_rec(1'b1, 1'b0, 2); valid = 1'b1; TxReady = 1'b1;
    cycle();
    valid = 1'b0;
    drain(100);
    chk("r31_size", last_frame.size(), 62);
    chk("r31_b0", last_frame[0], 8'h3C);
    chk("r31_b1", last_frame[1], 8'h00);

    // Bare record with PC=0x80000000
    rvvi = rand_rec(1'b0, 1'b0, 0); rvvi[63:0] = 64'h0000_0000_8000_0000; valid = 1'b1;
    cycle();
    valid = 1'b0;
    drain(100);
    chk("r32_size", last_frame.size(), 33);
    for (int i = 0; i < 8; i++) chk($sformatf("r32_pc%0d", i), last_frame[2+i], pc_bytes[i]);

    // CSR count above MAX_CSRS is clamped
    rvvi = rand_rec(1'b0, 1'b0, 7); valid = 1'b1;
    cycle();
    valid = 1'b0;
    drain(100);
    chk("r36_size", last_frame.size(), 83);
    chk("r36_len", last_frame[0], 81);

    // Fill with sink stalled: stall at 3, 5th dropped
    do_reset();
    TxReady = 1'b0;
    repeat (5) begin
      rvvi = rand_rec(1'($urandom), 1'($urandom), $urandom_range(0, 6));
      valid = 1'b1;
      cycle();
    end
    valid = 1'b0;
    cycle();
    chk("r33_stall", RvviStall, 1);
    chk("r33_ovf", Overflow, 1);
    frames_done = 0;
    drain(100);
    chk("r33_frames", frames_done, 4);

    // Back-pressure 1,0,0,1 mid-frame
    rvvi = rand_rec(1'b1, 1'b1, 3); valid = 1'b1; TxReady = 1'b1;
    cycle();
    valid = 1'b0;
    repeat (8) cycle();
    TxReady = 1'b0;
    cycle();
    cycle();
    TxReady = 1'b1;
    drain(100);

    // Reset mid-frame at byte 20
    do_reset();
    rvvi = rand_rec(1'b1, 1'b1, 5); valid = 1'b1; TxReady = 1'b1;
    cycle();
    valid = 1'b0;
    for (int n = 0; n < 100 && obs_frame.size() < 20; n++) cycle();
    chk("r35_reached20", obs_frame.size(), 20);
    do_reset();
    TxReady = 1'b1;
    cycle();
    rvvi = rand_rec(1'b0, 1'b0, 0); valid = 1'b1;
    cycle();
    valid = 1'b0;
    drain(100);
    chk("r35_size", last_frame.size(), 33);
    chk("r35_len", last_frame[0], 31);

    // Random traffic with random back-pressure
    do_reset();
    for (int c = 0; c < 400; c++) begin
      valid = ($urandom_range(2) == 0);
      if (valid) rvvi = rand_rec(1'($urandom), 1'($urandom), $urandom_range(0, 8));
      TxReady = ($urandom_range(3) != 0);
      cycle();
    end
    valid = 1'b0;
    drain(80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
